// File: rtl/mult_8x8_err_meter.sv
// Exhaustive error characterisation of an attached 8x8 multiplier.
// Sweeps all 65,536 operand pairs and accumulates error count, error distance sum/max and worst operands.
module mult_8x8_err_meter #(
  parameter int LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  input  logic [15:0] mult_r,
  output logic        busy,
  output logic        done,
  output logic [16:0] err_count,
  output logic [31:0] sum_ed,
  output logic [15:0] max_ed,
  output logic [7:0]  worst_a,
  output logic [7:0]  worst_b,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] idx_q;
  logic        busy_q;
  logic        done_q;
  logic        launch;
  logic        issue_v;
  logic        tag_v;
  logic [15:0] tag_ab;
  logic        stages_empty;
  logic        cmp_v_q;
  logic [15:0] ed_q;
  logic [7:0]  cmp_a_q;
  logic [7:0]  cmp_b_q;
  logic [15:0] prod;
  logic [16:0] err_count_q;
  logic [31:0] sum_ed_q;
  logic [15:0] max_ed_q;
  logic [7:0]  worst_a_q;
  logic [7:0]  worst_b_q;

  assign launch  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign issue_v = (state_q == S_SWEEP);

  // The issue index doubles as the operand register; it is held at 0 outside SWEEP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state_q <= S_SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (idx_q == 16'hFFFF) begin
            state_q <= S_DRAIN;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 16'd1;
          end
        end
        S_DRAIN: begin
          if (stages_empty && !cmp_v_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Valid chain: a tag at the last stage is valid exactly when mult_r belongs to its operands.
  if (LAT == 0) begin : g_nolat
    assign tag_v        = issue_v;
    assign tag_ab       = idx_q;
    assign stages_empty = 1'b1;
  end else begin : g_lat
    localparam int TW = 16 * LAT;
    logic [LAT-1:0] v_q;
    logic [TW-1:0]  tp_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q <= LAT'({v_q, issue_v});
      end
    end

    always_ff @(posedge clk) begin
      tp_q <= TW'({tp_q, idx_q});
    end

    assign tag_v        = v_q[LAT-1];
    assign tag_ab       = tp_q[TW-1 -: 16];
    assign stages_empty = (v_q == '0);
  end

  assign prod = {8'd0, tag_ab[15:8]} * {8'd0, tag_ab[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_v_q <= 1'b0;
      ed_q    <= '0;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
    end else begin
      cmp_v_q <= tag_v;
      if (tag_v) begin
        ed_q    <= (mult_r >= prod) ? (mult_r - prod) : (prod - mult_r);
        cmp_a_q <= tag_ab[15:8];
        cmp_b_q <= tag_ab[7:0];
      end
    end
  end

  // Strictly-greater update keeps the earliest pair in issue order on ties.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      worst_a_q   <= '0;
      worst_b_q   <= '0;
    end else if (cmp_v_q) begin
      err_count_q <= err_count_q + {16'd0, (ed_q != 16'd0)};
      sum_ed_q    <= sum_ed_q + {16'd0, ed_q};
      if (ed_q > max_ed_q) begin
        max_ed_q  <= ed_q;
        worst_a_q <= cmp_a_q;
        worst_b_q <= cmp_b_q;
      end
    end
  end

  assign mult_a    = idx_q[15:8];
  assign mult_b    = idx_q[7:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign worst_a   = worst_a_q;
  assign worst_b   = worst_b_q;
  assign dbg_state = state_q;

endmodule
